// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, bus-level ACK/NACK levels,
// R/W bit encoding and memory transfer direction.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_CHK,
    REG_ACK,
    WR_BYTE,
    WR_ACK,
    RD_FETCH,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_e;

  // SDA level during the 9th clock
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // LSB of the device address byte
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // RorW encoding toward the memory block
  localparam logic MEM_WR = 1'b1;
  localparam logic MEM_RD = 1'b0;

  // Address byte carries the 7-bit device address in its upper bits
  function automatic logic dev_match(input logic [7:0] b, input logic [6:0] addr);
    return b[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// SCL/SDA synchronizers plus one history stage; produces single-clk pulses
// for SCL edges and START/STOP conditions. Usable by master or slave.
module i2c_bus_sync_edge #(
  parameter int SYNCSTAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_p,
  output logic stop_p
);

  logic [SYNCSTAGES-1:0] scl_sync, sda_sync;
  logic                  scl_s, scl_h, sda_h;

  // Idle bus is high, so flops reset to 1 to avoid a fake edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= SYNCSTAGES'({scl_sync, scl});
      sda_sync <= SYNCSTAGES'({sda_sync, sda});
      scl_h    <= scl_s;
      sda_h    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNCSTAGES-1];
  assign sda_s    = sda_sync[SYNCSTAGES-1];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  // SCL must be high on both samples so an SDA change near an SCL edge
  // is not mistaken for START/STOP
  assign start_p  = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_p   = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/i2c_slave_bus_ctrl.sv
// I2C slave front end: address decode, register-address capture, and
// single-clk transfer strobes toward the slave memory block. Read data is
// returned on SDA through an open-drain pull-down.
module i2c_slave_bus_ctrl #(
  parameter logic [6:0] SLAVEADDR     = 7'h42,
  parameter int         ADDRESSLENGTH = 8,
  parameter int         SYNCSTAGES    = 2
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic                     Scl,
  input  logic                     SdaIn,
  output logic                     SdaPullDown,
  output logic [ADDRESSLENGTH-1:0] DirectionBuffer,
  output logic [7:0]               InputBuffer,
  input  logic [7:0]               OutputBuffer,
  input  logic                     AddressFound,
  output logic                     Enable,
  output logic                     Mode,
  output logic                     RorW,
  output logic                     Busy
);
  import i2c_pkg::*;

  logic       sda_s, scl_rise, scl_fall, start_p, stop_p;
  i2c_state_e state;
  logic [3:0] bitcnt;
  logic [7:0] sr;
  logic [7:0] rx_byte;
  logic       rw;

  i2c_bus_sync_edge #(.SYNCSTAGES(SYNCSTAGES)) u_sync (
    .clk      (Clk),
    .rst_n    (nReset),
    .scl      (Scl),
    .sda      (SdaIn),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_p  (start_p),
    .stop_p   (stop_p)
  );

  // Byte as it will look after the bit being sampled now is shifted in
  assign rx_byte = {sr[6:0], sda_s};

  // Protocol FSM; every output is registered here. STOP beats START beats
  // normal sequencing. In ACK states bitcnt is unused: the slave pulls SDA
  // on the first SCL fall and moves on at the 9th SCL rise, so the pull is
  // released (or replaced by read data) at the following fall.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state           <= IDLE;
      bitcnt          <= '0;
      sr              <= '0;
      rw              <= 1'b0;
      SdaPullDown     <= 1'b0;
      DirectionBuffer <= '0;
      InputBuffer     <= '0;
      Enable          <= 1'b0;
      Mode            <= 1'b0;
      RorW            <= 1'b0;
      Busy            <= 1'b0;
    end else begin
      Enable <= 1'b0;
      if (stop_p) begin
        state       <= IDLE;
        bitcnt      <= '0;
        SdaPullDown <= 1'b0;
        Busy        <= 1'b0;
      end else if (start_p) begin
        state       <= DEV_ADDR;
        bitcnt      <= '0;
        SdaPullDown <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR: if (scl_rise) begin
            sr     <= rx_byte;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              bitcnt <= '0;
              if (dev_match(rx_byte, SLAVEADDR)) begin
                state <= DEV_ACK;
                rw    <= sda_s;
                Busy  <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          DEV_ACK, REG_ACK, WR_ACK: begin
            if (scl_fall) SdaPullDown <= ~I2C_ACK;
            if (scl_rise) begin
              bitcnt <= '0;
              if (state == DEV_ACK) state <= (rw == RW_WRITE) ? REG_ADDR : RD_FETCH;
              else                  state <= WR_BYTE;
            end
          end
          REG_ADDR: begin
            if (scl_fall) SdaPullDown <= 1'b0;
            if (scl_rise) begin
              sr     <= rx_byte;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                DirectionBuffer <= ADDRESSLENGTH'(rx_byte);
                bitcnt          <= '0;
                state           <= REG_CHK;
              end
            end
          end
          // Two Clk for the memory lookup on the new DirectionBuffer
          REG_CHK: begin
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd1) begin
              bitcnt <= '0;
              if (AddressFound) begin
                state <= REG_ACK;
              end else begin
                state <= WAIT_STOP;
                Busy  <= 1'b0;
              end
            end
          end
          // bitcnt==8 marks the Clk right after the byte landed
          WR_BYTE: begin
            if (bitcnt == 4'd8) begin
              Enable <= 1'b1;
              Mode   <= 1'b1;
              RorW   <= MEM_WR;
              bitcnt <= '0;
              state  <= WR_ACK;
            end else begin
              if (scl_fall) SdaPullDown <= 1'b0;
              if (scl_rise) begin
                sr     <= rx_byte;
                bitcnt <= bitcnt + 4'd1;
                if (bitcnt == 4'd7) InputBuffer <= rx_byte;
              end
            end
          end
          // Strobe, then pick up OutputBuffer two Clk later
          RD_FETCH: begin
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd0) begin
              Enable <= 1'b1;
              Mode   <= 1'b1;
              RorW   <= MEM_RD;
            end
            if (bitcnt == 4'd2) begin
              sr     <= OutputBuffer;
              bitcnt <= '0;
              state  <= RD_BYTE;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              SdaPullDown <= 1'b0;
              bitcnt      <= '0;
              state       <= RD_ACK;
            end else begin
              SdaPullDown <= ~sr[7];
              sr          <= {sr[6:0], 1'b0};
              bitcnt      <= bitcnt + 4'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              state <= WAIT_STOP;
              Busy  <= 1'b0;
            end else begin
              bitcnt <= '0;
              state  <= RD_FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // rw keeps the R/W bit of the current transaction; RW_READ documents the other value
  logic unused_ok;
  assign unused_ok = (RW_READ != RW_WRITE);

endmodule

// File: tb/tb_i2c_slave_bus_ctrl.sv
// Bench for i2c_slave_bus_ctrl: bit-banged I2C master, a simple memory
// model, and expectations derived from the transaction-level bus rules.
module tb_i2c_slave_bus_ctrl;

  localparam int Q = 40; // quarter SCL period, 4 Clk

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic scl = 1'b1;
  logic msda = 1'b1;
  logic sda_line;
  logic SdaPullDown;
  logic [7:0] DirectionBuffer, InputBuffer;
  logic [7:0] OutputBuffer = 8'h00;
  logic AddressFound, Enable, Mode, RorW, Busy;

  logic [255:0] hit = '0;
  logic [7:0]   rd_q[$];
  logic [7:0]   wr_log[$];
  logic [7:0]   wdata[4];
  logic [7:0]   rdata[4];
  int n_chk = 0, n_fail = 0;
  int en_cnt = 0, rd_cnt = 0, b2b = 0, mode_bad = 0;
  bit pd_any = 0, busy_any = 0, en_prev = 0;

  i2c_slave_bus_ctrl #(.SLAVEADDR(7'h42), .ADDRESSLENGTH(8), .SYNCSTAGES(2)) dut (
    .Clk(Clk), .nReset(nReset), .Scl(scl), .SdaIn(sda_line),
    .SdaPullDown(SdaPullDown), .DirectionBuffer(DirectionBuffer),
    .InputBuffer(InputBuffer), .OutputBuffer(OutputBuffer),
    .AddressFound(AddressFound), .Enable(Enable), .Mode(Mode),
    .RorW(RorW), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Open-drain wired-AND
  assign sda_line     = msda & ~SdaPullDown;
  assign AddressFound = hit[DirectionBuffer];

  // Memory: a read strobe presents the next queued byte one Clk later
  always @(posedge Clk)
    if (Enable && !RorW) begin
      if (rd_q.size() != 0) OutputBuffer <= rd_q.pop_front();
      else                  OutputBuffer <= 8'hFF;
    end

  // Strobe / bus activity monitor
  always @(negedge Clk) begin
    if (nReset && Enable) begin
      en_cnt++;
      if (RorW) wr_log.push_back(InputBuffer);
      else      rd_cnt++;
      if (!Mode)   mode_bad++;
      if (en_prev) b2b++;
    end
    en_prev = Enable;
    if (SdaPullDown) pd_any = 1;
    if (Busy)        busy_any = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    en_cnt = 0; rd_cnt = 0; pd_any = 0; busy_any = 0;
    wr_log.delete();
  endtask

  task automatic i2c_start();
    #Q msda = 1'b1; #Q scl = 1'b1; #Q msda = 1'b0; #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q msda = 1'b0; #Q scl = 1'b1; #Q msda = 1'b1; #Q;
  endtask

  task automatic i2c_wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      #Q msda = b[i]; #Q scl = 1'b1; #Q; #Q scl = 1'b0;
    end
    #Q msda = 1'b1; #Q scl = 1'b1; #Q ack = sda_line; #Q scl = 1'b0;
  endtask

  task automatic i2c_rbyte(input logic nack, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      #Q msda = 1'b1; #Q scl = 1'b1; #Q b = {b[6:0], sda_line}; #Q scl = 1'b0;
    end
    #Q msda = nack; #Q scl = 1'b1; #Q; #Q scl = 1'b0;
  endtask

  // Write: device byte, register byte, n data bytes, STOP
  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] ra, input int n);
    logic a;
    bit dh, rh;
    logic [7:0] db0;
    dh  = (dev[7:1] == 7'h42) && (dev[0] == 1'b0);
    rh  = dh && hit[ra];
    db0 = DirectionBuffer;
    clr_mon();
    i2c_start();
    i2c_wbyte(dev, a);
    chk("dev_ack", 32'(a), dh ? 0 : 1);
    chk("busy_addr", 32'(Busy), 32'(dh));
    i2c_wbyte(ra, a);
    chk("reg_ack", 32'(a), rh ? 0 : 1);
    pd_any = 0;
    for (int i = 0; i < n; i++) begin
      i2c_wbyte(wdata[i], a);
      chk("wr_ack", 32'(a), rh ? 0 : 1);
    end
    i2c_stop();
    #(2*Q);
    chk("busy_stop", 32'(Busy), 0);
    chk("wr_en", en_cnt, rh ? n : 0);
    chk("wr_cnt", wr_log.size(), rh ? n : 0);
    if (rh) begin
      for (int i = 0; i < n && i < wr_log.size(); i++) chk("wr_byte", 32'(wr_log[i]), 32'(wdata[i]));
      chk("inbuf", 32'(InputBuffer), 32'(wdata[n-1]));
    end else begin
      chk("pd_rel", 32'(pd_any), 0);
    end
    chk("dirbuf", 32'(DirectionBuffer), 32'(dh ? ra : db0));
    if (!dh) chk("busy_nodev", 32'(busy_any), 0);
  endtask

  // Read: device byte 0x85, n bytes, master NACKs the last one
  task automatic rd_txn(input int n);
    logic a;
    logic [7:0] b;
    clr_mon();
    rd_q.delete();
    for (int i = 0; i < n; i++) rd_q.push_back(rdata[i]);
    i2c_start();
    i2c_wbyte(8'h85, a);
    chk("rdev_ack", 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      i2c_rbyte(i == n-1, b);
      chk("rd_byte", 32'(b), 32'(rdata[i]));
    end
    #(2*Q);
    chk("rd_nack_busy", 32'(Busy), 0);
    i2c_stop();
    #(2*Q);
    chk("rd_en", rd_cnt, n);
    chk("rd_wr", wr_log.size(), 0);
  endtask

  initial begin
    logic a;
    logic [7:0] b, ra, dev;
    int n;

    #2;
    #30;
    chk("rst_pd",   32'(SdaPullDown), 0);
    chk("rst_dir",  32'(DirectionBuffer), 0);
    chk("rst_inb",  32'(InputBuffer), 0);
    chk("rst_en",   32'(Enable), 0);
    chk("rst_mode", 32'(Mode), 0);
    chk("rst_rw",   32'(RorW), 0);
    chk("rst_busy", 32'(Busy), 0);
    nReset = 1'b1;
    #(4*Q);

    // Directed write hit
    hit[8'h10] = 1'b1;
    wdata[0] = 8'hA5;
    wr_txn(8'h84, 8'h10, 1);
    // Register address miss
    hit[8'h77] = 1'b0;
    wdata[0] = 8'h3E;
    wr_txn(8'h84, 8'h77, 1);
    // Wrong device
    wr_txn(8'h90, 8'h10, 1);
    // Directed read
    rdata[0] = 8'h3C; rdata[1] = 8'hC3;
    rd_txn(2);

    // Repeated START: write pointer then read without STOP
    hit[8'h20] = 1'b1;
    clr_mon();
    rd_q.delete(); rd_q.push_back(8'h5A);
    i2c_start();
    i2c_wbyte(8'h84, a); chk("sr_dev_w", 32'(a), 0);
    i2c_wbyte(8'h20, a); chk("sr_reg", 32'(a), 0);
    i2c_start();
    i2c_wbyte(8'h85, a); chk("sr_dev_r", 32'(a), 0);
    i2c_rbyte(1'b1, b);  chk("sr_rd", 32'(b), 32'h5A);
    i2c_stop();
    #(2*Q);
    chk("sr_dir", 32'(DirectionBuffer), 32'h20);
    chk("sr_en", en_cnt, 1);
    chk("sr_rdcnt", rd_cnt, 1);

    // Randomized transactions
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        ra = 8'($urandom);
        hit[ra] = ($urandom_range(0, 3) != 0);
        dev = ($urandom_range(0, 4) == 0) ? {7'h42 ^ 7'($urandom_range(1, 127)), 1'b0} : 8'h84;
        for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
        wr_txn(dev, ra, n);
      end else begin
        for (int i = 0; i < n; i++) rdata[i] = 8'($urandom);
        rd_txn(n);
      end
    end

    // Reset during bit 4 of a read byte of all zeros (SDA pulled)
    clr_mon();
    rd_q.delete(); rd_q.push_back(8'h00);
    i2c_start();
    i2c_wbyte(8'h85, a);
    chk("mr_dev", 32'(a), 0);
    for (int i = 0; i < 4; i++) begin
      #Q msda = 1'b1; #Q scl = 1'b1; #Q; #Q scl = 1'b0;
    end
    #Q msda = 1'b1; #Q scl = 1'b1; #(Q/2);
    chk("mr_pd_pre", 32'(SdaPullDown), 1);
    nReset = 1'b0;
    #1;
    chk("mr_pd", 32'(SdaPullDown), 0);
    chk("mr_en", 32'(Enable), 0);
    chk("mr_busy", 32'(Busy), 0);
    #(Q/2 - 1);
    #Q nReset = 1'b1;
    #(2*Q);
    clr_mon();
    i2c_start();
    i2c_wbyte(8'h84, a);
    chk("mr_rec_ack", 32'(a), 0);
    chk("mr_rec_busy", 32'(Busy), 1);
    i2c_stop();
    #(2*Q);
    chk("mr_rec_idle", 32'(Busy), 0);

    chk("en_b2b", b2b, 0);
    chk("en_mode", mode_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
